// File: rtl/m1_bus_initiator_if.sv
// Command and MyBus handshake bundle between the M1 initiator and its local requester / M2.
interface m1_bus_initiator_if #(
    parameter int PEND_W = 3
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              bus_ready;
    logic              bus_execute;
    logic              done_pulse;
    logic              err_pulse;
    logic [PEND_W-1:0] pend_cnt;

    modport master (
        input  cmd_valid,
        input  bus_execute,
        output cmd_ready,
        output bus_ready,
        output done_pulse,
        output err_pulse,
        output pend_cnt
    );

    modport slave (
        output cmd_valid,
        output bus_execute,
        input  cmd_ready,
        input  bus_ready,
        input  done_pulse,
        input  err_pulse,
        input  pend_cnt
    );
endinterface

// File: rtl/m1_bus_initiator.sv
// M1 bus initiator: queues local commands and offers each to M2 over MyBus ready/execute,
// retiring it on execute (done) or on timeout / power-domain isolation (err).
//   state     | meaning
//   IDLE      | nothing offered, waiting for a pending command
//   OFFER     | bus_ready high for this single cycle
//   WAIT_EXEC | waiting for execute, timeout counter running
//   RETIRE    | done_pulse or err_pulse high, pend_cnt already decremented
module m1_bus_initiator #(
    parameter int PEND_W  = 3,
    parameter int TMO_CYC = 8
) (
    input  logic                ck,
    input  logic                srst_n,
    input  logic                isolateM1M2,
    m1_bus_initiator_if.master  bus
);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [7:0]        TMO_LAST = 8'(TMO_CYC - 1);

    typedef enum logic [1:0] {IDLE, OFFER, WAIT_EXEC, RETIRE} state_t;

    state_t            state;
    logic [7:0]        tmo;
    logic [PEND_W-1:0] pend;
    logic [PEND_W-1:0] pend_next;
    logic              room;
    logic              bus_ready_q;
    logic              done_q;
    logic              err_q;
    logic              exec_eff;
    logic              accept;
    logic              fin_ok;
    logic              fin_err;
    logic              retire;
    logic              go_offer;

    always_comb begin
        exec_eff = bus.bus_execute & ~isolateM1M2;
        accept   = bus.cmd_valid & room & ~isolateM1M2;
        fin_ok   = (state == WAIT_EXEC) & exec_eff;
        // Isolation wins over execute; timeout only when execute is absent on the last cycle.
        fin_err  = (((state == OFFER) | (state == WAIT_EXEC)) & isolateM1M2)
                 | ((state == WAIT_EXEC) & ~exec_eff & (tmo == TMO_LAST));
        retire   = fin_ok | fin_err;
        go_offer = ((state == IDLE) | (state == RETIRE)) & (pend != '0) & ~isolateM1M2;
        pend_next = pend;
        if (accept & ~retire) begin
            pend_next = pend + 1'b1;
        end else if (~accept & retire) begin
            pend_next = pend - 1'b1;
        end
    end

    always_ff @(posedge ck) begin
        if (!srst_n) begin
            state       <= IDLE;
            tmo         <= '0;
            pend        <= '0;
            room        <= 1'b0;
            bus_ready_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            bus_ready_q <= 1'b0;
            done_q      <= fin_ok;
            err_q       <= fin_err;
            pend        <= pend_next;
            room        <= (pend_next != PEND_MAX);
            case (state)
                IDLE, RETIRE: begin
                    if (go_offer) begin
                        state       <= OFFER;
                        bus_ready_q <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                OFFER: begin
                    tmo   <= '0;
                    state <= isolateM1M2 ? RETIRE : WAIT_EXEC;
                end
                WAIT_EXEC: begin
                    if (retire) begin
                        state <= RETIRE;
                    end else begin
                        tmo <= tmo + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // cmd_ready drops in the same cycle isolation is raised so nothing is queued while isolated.
    assign bus.cmd_ready  = room & ~isolateM1M2;
    assign bus.bus_ready  = bus_ready_q;
    assign bus.done_pulse = done_q;
    assign bus.err_pulse  = err_q;
    assign bus.pend_cnt   = pend;
endmodule

// File: tb/tb_m1_bus_initiator.sv
// Bench for m1_bus_initiator: transaction-age reference model checked every cycle, plus directed scenarios.
module tb_m1_bus_initiator;
    localparam int PEND_W  = 3;
    localparam int TMO_CYC = 8;
    localparam int MAXP    = (1 << PEND_W) - 1;

    logic ck = 1'b0;
    logic srst_n = 1'b0;
    logic iso = 1'b0;
    logic cmd_valid = 1'b0;
    logic echo_en = 1'b1;
    logic echo_q = 1'b0;
    logic stray = 1'b0;

    m1_bus_initiator_if #(.PEND_W(PEND_W)) bif();

    m1_bus_initiator #(.PEND_W(PEND_W), .TMO_CYC(TMO_CYC)) dut (
        .ck          (ck),
        .srst_n      (srst_n),
        .isolateM1M2 (iso),
        .bus         (bif)
    );

    always #5 ck = ~ck;

    // M2 echo: execute is ready delayed by one cycle.
    always @(posedge ck) echo_q <= bif.bus_ready;
    assign bif.bus_execute = (echo_en & echo_q) | stray;
    assign bif.cmd_valid   = cmd_valid;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #2;
    endtask

    // Reference model: a transaction is tracked by its age in cycles since its bus_ready cycle.
    bit m_ok = 0;
    int m_pend = 0;
    bit m_room = 0;
    bit m_busy = 0;
    int m_age = 0;
    bit e_ready = 0, e_done = 0, e_err = 0;
    bit acc, fin_d, fin_e, start;

    always @(posedge ck) begin
        if (!srst_n) begin
            m_ok = 1; m_pend = 0; m_room = 0; m_busy = 0; m_age = 0;
            e_ready = 0; e_done = 0; e_err = 0;
        end else if (m_ok) begin
            acc   = cmd_valid && m_room && !iso;
            fin_d = 0;
            fin_e = 0;
            if (m_busy) begin
                if (iso) fin_e = 1;
                else if (m_age >= 1 && bif.bus_execute) fin_d = 1;
                else if (m_age == TMO_CYC) fin_e = 1;
                else m_age++;
            end
            start = !m_busy && m_pend > 0 && !iso;
            if (fin_d || fin_e) m_busy = 0;
            if (start) begin
                m_busy = 1;
                m_age  = 0;
            end
            m_pend = m_pend + (acc ? 1 : 0) - ((fin_d || fin_e) ? 1 : 0);
            m_room = (m_pend < MAXP);
            e_ready = start;
            e_done  = fin_d;
            e_err   = fin_e;
        end
    end

    always @(negedge ck) begin
        if (m_ok) begin
            check("cmd_ready", int'(bif.cmd_ready), int'(m_room && !iso));
            check("bus_ready", int'(bif.bus_ready), int'(e_ready));
            check("done_pulse", int'(bif.done_pulse), int'(e_done));
            check("err_pulse", int'(bif.err_pulse), int'(e_err));
            check("pend_cnt", int'(bif.pend_cnt), m_pend);
        end
    end

    initial begin
        int acc_n, last, nerr, r_t, e_t, dn, seen;

        // Reset state
        tick(); tick(); tick();
        check("rst_pend", int'(bif.pend_cnt), 0);
        check("rst_cmd_ready", int'(bif.cmd_ready), 0);
        check("rst_bus_ready", int'(bif.bus_ready), 0);
        srst_n = 1'b1;
        tick();
        check("post_rst_cmd_ready", int'(bif.cmd_ready), 1);

        // Single command with echo: ready at N+2, done at N+4
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("single_pend1", int'(bif.pend_cnt), 1);
        tick();
        check("single_ready_n2", int'(bif.bus_ready), 1);
        tick();
        tick();
        check("single_done_n4", int'(bif.done_pulse), 1);
        check("single_pend0", int'(bif.pend_cnt), 0);
        tick();

        // Fill to capacity with no execute, then drain by timeouts
        echo_en = 1'b0;
        cmd_valid = 1'b1;
        acc_n = 0;
        for (int i = 0; i < 20; i++) begin
            if (bif.cmd_ready) acc_n++;
            tick();
            if (!bif.cmd_ready) break;
        end
        check("fill_accepts", acc_n, MAXP);
        check("fill_pend", int'(bif.pend_cnt), MAXP);
        tick();
        check("fill_no_wrap", int'(bif.pend_cnt), MAXP);
        cmd_valid = 1'b0;
        last = -1;
        nerr = 0;
        for (int t = 0; t < 150 && bif.pend_cnt != 0; t++) begin
            tick();
            if (bif.err_pulse) begin
                if (last >= 0) check("fill_err_period", t - last, TMO_CYC + 2);
                last = t;
                nerr++;
            end
        end
        check("fill_err_count", nerr, MAXP);
        tick();

        // Single timeout: err 9 cycles after bus_ready, no done
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        r_t = -100; e_t = -1; dn = 0;
        for (int t = 0; t < 30; t++) begin
            tick();
            if (bif.bus_ready && r_t < 0) r_t = t;
            if (bif.err_pulse && e_t < 0) e_t = t;
            if (bif.done_pulse) dn++;
        end
        check("timeout_gap", e_t - r_t, TMO_CYC + 1);
        check("timeout_no_done", dn, 0);
        check("timeout_pend", int'(bif.pend_cnt), 0);

        // Isolation during WAIT_EXEC with 3 pending
        cmd_valid = 1'b1;
        tick(); tick(); tick();
        cmd_valid = 1'b0;
        check("iso_pend3", int'(bif.pend_cnt), 3);
        tick();
        iso = 1'b1;
        tick();
        check("iso_err", int'(bif.err_pulse), 1);
        check("iso_pend2", int'(bif.pend_cnt), 2);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("iso_bus_ready_low", int'(bif.bus_ready), 0);
            check("iso_cmd_ready_low", int'(bif.cmd_ready), 0);
        end
        check("iso_hold_pend", int'(bif.pend_cnt), 2);

        // Release with echo; accept coincides with the following done at pend_cnt=2
        iso = 1'b0;
        echo_en = 1'b1;
        seen = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (bif.bus_ready) begin
                seen = 1;
                break;
            end
        end
        check("release_ready_within_2", seen, 1);
        tick();
        check("simul_pend_before", int'(bif.pend_cnt), 2);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("simul_done", int'(bif.done_pulse), 1);
        check("simul_pend_after", int'(bif.pend_cnt), 2);
        for (int i = 0; i < 60 && bif.pend_cnt != 0; i++) tick();
        check("drain_pend", int'(bif.pend_cnt), 0);
        tick(); tick();

        // One-cycle reset in WAIT_EXEC with 4 pending
        echo_en = 1'b0;
        cmd_valid = 1'b1;
        tick(); tick(); tick(); tick();
        cmd_valid = 1'b0;
        check("rst4_pend4", int'(bif.pend_cnt), 4);
        srst_n = 1'b0;
        tick();
        srst_n = 1'b1;
        check("rst4_pend0", int'(bif.pend_cnt), 0);
        check("rst4_bus_ready", int'(bif.bus_ready), 0);
        check("rst4_done", int'(bif.done_pulse), 0);
        check("rst4_err", int'(bif.err_pulse), 0);
        check("rst4_cmd_ready_in_rst", int'(bif.cmd_ready), 0);
        tick();
        check("rst4_cmd_ready_after", int'(bif.cmd_ready), 1);
        check("rst4_no_err_after", int'(bif.err_pulse), 0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            srst_n = ($urandom_range(0, 399) != 0);
            cmd_valid = ($urandom_range(0, 99) < 45);
            if ($urandom_range(0, 99) < 3) iso = ~iso;
            if (c % 64 == 0) echo_en = ($urandom_range(0, 9) < 7);
            stray = ($urandom_range(0, 99) < 5);
            tick();
        end
        stray = 1'b0;
        cmd_valid = 1'b0;
        iso = 1'b0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/m1_bus_initiator.md
M1_BUS_INITIATOR -- requirements
Module: m1_bus_initiator

Interface
REQ-001 Parameter: PEND_W, default 3; width of the pending-command counter (capacity 2**PEND_W-1).
REQ-002 Parameter: TMO_CYC, default 8; cycles to wait for execute before declaring timeout, legal 2..255.
REQ-003 Port: ck  input  1  sole clock, all state updates on its rising edge.
REQ-004 Port: srst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: isolateM1M2  input  1  isolation enable between M1 and M2 power domains.
REQ-006 Port: cmd_valid  input  1  local request to issue one bus transaction.
REQ-007 Port: cmd_ready  output  1  request accepted when cmd_valid and cmd_ready both high.
REQ-008 Port: bus_ready  output  1  ready field of MyBus segment S5, driven toward M2.
REQ-009 Port: bus_execute  input  1  execute field of MyBus segment S6, returned from M2 (M2 registers execute from ready, one-cycle latency).
REQ-010 Port: done_pulse  output  1  one-cycle pulse per completed transaction.
REQ-011 Port: err_pulse  output  1  one-cycle pulse per aborted transaction (timeout or isolation).
REQ-012 Port: pend_cnt  output  PEND_W  number of accepted, not yet retired commands.

Function
REQ-013 cmd_ready SHALL be high iff pend_cnt < 2**PEND_W-1 and isolateM1M2 is low.
REQ-014 pend_cnt SHALL increment on accept, decrement on done or abort, and stay unchanged when both occur in the same cycle; it SHALL never wrap.
REQ-015 FSM states: IDLE, OFFER, WAIT_EXEC, RETIRE; all outputs registered.
REQ-016 IDLE -> OFFER when pend_cnt > 0 and isolateM1M2 low; otherwise remain.
REQ-017 OFFER: bus_ready=1 for exactly one cycle; next state WAIT_EXEC; timeout counter loads 0.
REQ-018 WAIT_EXEC: bus_ready=0; counter increments each cycle; bus_execute=1 -> RETIRE with done; counter reaching TMO_CYC-1 without execute -> RETIRE with abort.
REQ-019 RETIRE: done_pulse or err_pulse (never both) high for one cycle, pend_cnt decremented; next state OFFER if remaining pend_cnt > 0 and not isolated, else IDLE.
REQ-020 Minimum transaction latency: bus_ready cycle N, bus_execute sampled high at N+1, done_pulse at N+2; back-to-back throughput one transaction per 3 cycles.
REQ-021 bus_execute SHALL be ignored in IDLE, OFFER and RETIRE; a stray execute pulse causes no state change.
REQ-022 isolateM1M2 high: bus_ready forced 0 combinationally-free (registered clamp, effective next cycle); in OFFER or WAIT_EXEC the transaction aborts -> RETIRE with err_pulse; remaining pending commands stay queued.
REQ-023 While isolateM1M2 high the FSM SHALL stay in IDLE after RETIRE; bus_execute SHALL be treated as 0.
REQ-024 Deassertion of isolateM1M2 with pend_cnt > 0 SHALL start OFFER no earlier than the following cycle.

Reset
REQ-025 srst_n low at a rising ck edge SHALL set state IDLE, pend_cnt 0, timeout counter 0, bus_ready 0, done_pulse 0, err_pulse 0, cmd_ready 0 during reset.
REQ-026 Reset mid-transaction SHALL discard all pending commands with no done or err pulse; cmd_ready high the first cycle after srst_n high (if not isolated).
REQ-027 Asynchronous assertion of srst_n SHALL have no effect until the next rising ck edge.

Verification
REQ-028 Single command, M2 echo model active: cmd_valid 1 cycle at N -> bus_ready high at N+2, done_pulse at N+4, pend_cnt 1 then 0.
REQ-029 Fill: PEND_W=3, cmd_valid held, no execute -> cmd_ready low after 7 accepts, pend_cnt=7, no wrap; then err_pulse every TMO_CYC+2 cycles until empty.
REQ-030 Timeout: bus_execute tied 0, TMO_CYC=8 -> err_pulse 9 cycles after bus_ready, pend_cnt decrements, no done_pulse.
REQ-031 Isolation during WAIT_EXEC with 3 pending -> one err_pulse, pend_cnt=2, bus_ready stays 0 until release; after release bus_ready pulses within 2 cycles.
REQ-032 Simultaneous accept and done with pend_cnt=2 -> pend_cnt stays 2.
REQ-033 srst_n low for 1 cycle in WAIT_EXEC with pend_cnt=4 -> next cycle pend_cnt=0, bus_ready=0, no done or err pulse.
